// File: rtl/adder_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
package adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 8;
  localparam int CLA_GROUP           = 4;

  // Number of 4-bit lookahead groups needed to cover a given operand width.
  function automatic int num_groups(input int width);
    return (width + CLA_GROUP - 1) / CLA_GROUP;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group: internal bit carries plus group G/P
// for the second-level lookahead.
module cla_group4 (
  input  logic [3:0] i_p,
  input  logic [3:0] i_g,
  input  logic       i_c,
  output logic [3:0] o_c,
  output logic       o_gg,
  output logic       o_gp
);

  // o_c[n] is the carry into bit n of the group, fully flattened.
  always_comb begin
    o_c[0] = i_c;
    o_c[1] = i_g[0] | (i_p[0] & i_c);
    o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
    o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
           | (i_p[2] & i_p[1] & i_p[0] & i_c);
    o_gg   = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
           | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    o_gp   = &i_p;
  end

endmodule

// File: rtl/adder_unit.sv
// Registered unsigned adder: two-level carry-lookahead network feeding
// a single output register stage. tot is always {carry, sum}.
module adder_unit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH:0]   tot
);

  localparam int   NG       = num_groups(WIDTH);
  localparam int   PW       = NG * CLA_GROUP;
  localparam logic CARRY_IN = 1'b0;

  logic [PW-1:0]    w_a;
  logic [PW-1:0]    w_b;
  logic [PW-1:0]    w_p;
  logic [PW-1:0]    w_g;
  logic [PW-1:0]    w_c;
  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic [NG:0]      w_cg;
  logic [PW:0]      w_c_all;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;

  // Zero-extend to a whole number of groups; padding bits never generate
  // or propagate, so they cannot disturb the real carry chain.
  assign w_a = PW'(a_i);
  assign w_b = PW'(b_i);
  assign w_p = w_a ^ w_b;
  assign w_g = w_a & w_b;

  // Second-level lookahead: carry into each group from the group G/P terms.
  always_comb begin
    logic v_acc;
    logic v_term;
    v_acc   = 1'b0;
    v_term  = 1'b0;
    w_cg    = '0;
    w_cg[0] = CARRY_IN;
    for (int k = 1; k <= NG; k++) begin
      v_acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        v_term = w_gg[j];
        for (int m = j + 1; m < k; m++) v_term = v_term & w_gp[m];
        v_acc = v_acc | v_term;
      end
      v_term = CARRY_IN;
      for (int m = 0; m < k; m++) v_term = v_term & w_gp[m];
      w_cg[k] = v_acc | v_term;
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .i_p  (w_p[k*CLA_GROUP +: CLA_GROUP]),
      .i_g  (w_g[k*CLA_GROUP +: CLA_GROUP]),
      .i_c  (w_cg[k]),
      .o_c  (w_c[k*CLA_GROUP +: CLA_GROUP]),
      .o_gg (w_gg[k]),
      .o_gp (w_gp[k])
    );
  end

  // Carry-out is taken at bit WIDTH, not at the padded width.
  assign w_c_all = {w_cg[NG], w_c};
  assign w_sum   = w_p[WIDTH-1:0] ^ w_c[WIDTH-1:0];
  assign w_carry = w_c_all[WIDTH];

  // Output register: load on valid_i, otherwise hold; valid_o pulses per load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
    end
  end

  assign valid_o = r_valid;
  assign sum     = r_sum;
  assign carry   = r_carry;
  assign tot     = {r_carry, r_sum};

endmodule

// File: tb/tb_adder_unit.sv
module tb_adder_unit;

  logic clk;
  logic rst;

  logic        v8, v5, v1, v16;
  logic [7:0]  a8, b8;
  logic [4:0]  a5, b5;
  logic [0:0]  a1, b1;
  logic [15:0] a16, b16;

  logic        vo8, vo5, vo1, vo16;
  logic [7:0]  s8;
  logic [4:0]  s5;
  logic [0:0]  s1;
  logic [15:0] s16;
  logic        c8, c5, c1, c16;
  logic [8:0]  t8;
  logic [5:0]  t5;
  logic [1:0]  t1;
  logic [16:0] t16;

  logic [16:0] q8[$];
  logic [16:0] q5[$];
  logic [16:0] q1[$];
  logic [16:0] q16[$];
  logic [16:0] e8, e5, e1, e16;

  int checks = 0;
  int errors = 0;

  adder_unit #(.WIDTH(8)) u_w8 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8), .a_i(a8), .b_i(b8),
    .valid_o(vo8), .sum(s8), .carry(c8), .tot(t8));
  adder_unit #(.WIDTH(5)) u_w5 (
    .clk_i(clk), .rst_i(rst), .valid_i(v5), .a_i(a5), .b_i(b5),
    .valid_o(vo5), .sum(s5), .carry(c5), .tot(t5));
  adder_unit #(.WIDTH(1)) u_w1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1), .a_i(a1), .b_i(b1),
    .valid_o(vo1), .sum(s1), .carry(c1), .tot(t1));
  adder_unit #(.WIDTH(16)) u_w16 (
    .clk_i(clk), .rst_i(rst), .valid_i(v16), .a_i(a16), .b_i(b16),
    .valid_o(vo16), .sum(s16), .carry(c16), .tot(t16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop the oldest expected result whenever a DUT flags valid_o.
  always @(negedge clk) begin
    if (!rst && vo8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8_spurious: valid_o=1 with tot=0x%0h, expected no result", t8);
      end else begin
        e8 = q8.pop_front();
        check("w8_tot", 64'(t8), 64'(e8));
        check("w8_pack", 64'(t8), 64'({c8, s8}));
      end
    end
    if (!rst && vo5 === 1'b1) begin
      if (q5.size() == 0) begin
        checks++; errors++;
        $display("FAIL w5_spurious: valid_o=1 with tot=0x%0h, expected no result", t5);
      end else begin
        e5 = q5.pop_front();
        check("w5_tot", 64'(t5), 64'(e5));
        check("w5_pack", 64'(t5), 64'({c5, s5}));
      end
    end
    if (!rst && vo1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL w1_spurious: valid_o=1 with tot=0x%0h, expected no result", t1);
      end else begin
        e1 = q1.pop_front();
        check("w1_tot", 64'(t1), 64'(e1));
        check("w1_pack", 64'(t1), 64'({c1, s1}));
      end
    end
    if (!rst && vo16 === 1'b1) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL w16_spurious: valid_o=1 with tot=0x%0h, expected no result", t16);
      end else begin
        e16 = q16.pop_front();
        check("w16_tot", 64'(t16), 64'(e16));
        check("w16_pack", 64'(t16), 64'({c16, s16}));
      end
    end
  end

  task automatic put8(input logic [7:0] a, input logic [7:0] b, input logic [16:0] exp);
    a8 = a; b8 = b; v8 = 1'b1;
    q8.push_back(exp);
    step();
  endtask

  task automatic put5(input logic [4:0] a, input logic [4:0] b, input logic [16:0] exp);
    a5 = a; b5 = b; v5 = 1'b1;
    q5.push_back(exp);
    step();
  endtask

  initial begin
    rst = 1'b1;
    v8 = 0; v5 = 0; v1 = 0; v16 = 0;
    a8 = 0; b8 = 0; a5 = 0; b5 = 0; a1 = 0; b1 = 0; a16 = 0; b16 = 0;
    #1;
    check("reset_valid8", 64'(vo8), 64'h0);
    check("reset_tot8", 64'(t8), 64'h0);
    check("reset_tot5", 64'(t5), 64'h0);
    check("reset_tot1", 64'(t1), 64'h0);
    check("reset_tot16", 64'(t16), 64'h0);
    step();
    step();
    rst = 1'b0;

    // WIDTH=8 directed vectors
    put8(8'h95, 8'hD2, 17'h167);
    put8(8'hFF, 8'h01, 17'h100);
    put8(8'hFF, 8'hFF, 17'h1FE);
    put8(8'h12, 8'h34, 17'h046);
    v8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    step();
    check("w8_hold_tot", 64'(t8), 64'h046);
    check("w8_hold_sum", 64'(s8), 64'h46);
    check("w8_hold_valid", 64'(vo8), 64'h0);

    // Async reset pulsed between edges while a result is on the outputs
    put8(8'h20, 8'h30, 17'h050);
    v8 = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("w8_async_tot", 64'(t8), 64'h0);
    check("w8_async_valid", 64'(vo8), 64'h0);
    #1 rst = 1'b0;
    step();
    put8(8'h40, 8'hC1, 17'h101);

    // Reset held across an edge with valid_i high: nothing is loaded
    v8 = 1'b0;
    @(negedge clk);
    #1;
    a8 = 8'h01; b8 = 8'h01; v8 = 1'b1; rst = 1'b1;
    step();
    check("w8_rst_edge_valid", 64'(vo8), 64'h0);
    check("w8_rst_edge_tot", 64'(t8), 64'h0);
    v8 = 1'b0;
    rst = 1'b0;
    step();
    put8(8'h7F, 8'h80, 17'h0FF);
    v8 = 1'b0;

    // WIDTH=5: carry from bit 4, not from the padded width
    put5(5'h1F, 5'h01, 17'h20);
    put5(5'h10, 5'h10, 17'h20);
    put5(5'h0A, 5'h05, 17'h0F);
    put5(5'h1F, 5'h1F, 17'h3E);
    v5 = 1'b0;

    // Back-to-back random traffic on all widths
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);  b8 = 8'($urandom);
      a5 = 5'($urandom);  b5 = 5'($urandom);
      a1 = 1'($urandom);  b1 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      v8 = 1'b1; v5 = 1'b1; v1 = 1'b1; v16 = 1'b1;
      q8.push_back(17'(a8) + 17'(b8));
      q5.push_back(17'(a5) + 17'(b5));
      q1.push_back(17'(a1) + 17'(b1));
      q16.push_back(17'(a16) + 17'(b16));
      step();
    end
    v8 = 0; v5 = 0; v1 = 0; v16 = 0;
    step();
    step();

    check("w8_drain", 64'(q8.size()), 64'h0);
    check("w5_drain", 64'(q5.size()), 64'h0);
    check("w1_drain", 64'(q1.size()), 64'h0);
    check("w16_drain", 64'(q16.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
